// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// NREQ requesters compete for the register's single write port. The grant is
// registered and one-hot. A granted requester may hold the port for a locked
// burst of at most MAX_BURST writes. Every release is followed by at least
// one idle cycle before the next grant.
//
// Optional feature macro: REG_WRITE_ARBITER_STATS_EN
//   When it is defined, the wr_count and burst_trunc outputs are added.
//
// Ports:
//   clk          system clock; all state changes on its rising edge
//   reset        asynchronous active-low reset
//   req[NREQ]    request per requester
//   lock[NREQ]   requester asks to keep ownership for a burst
//   wdata        requester i drives bits [i*WIDTH +: WIDTH]
//   gnt[NREQ]    registered one-hot grant; zero when idle
//   q[WIDTH]     shared register contents
//   q_valid      sticky flag; set by the first write after reset
//   owner        index of the last requester that wrote q
//   wr_count     (stats) saturating count of writes to q
//   burst_trunc  (stats) one-cycle pulse when MAX_BURST forces a release
//                while lock is still asserted
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    localparam int IDXW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [IDXW-1:0]       owner
`ifdef REG_WRITE_ARBITER_STATS_EN
    ,
    output logic [15:0]           wr_count,
    output logic                  burst_trunc
`endif
);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic [IDXW-1:0]   owner_q, owner_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   gidx_q, gidx_d;     // index of the current grant holder
    logic [3:0]        burst_q, burst_d;   // writes made in the current grant
`ifdef REG_WRITE_ARBITER_STATS_EN
    logic [15:0]       wr_count_q, wr_count_d;
    logic              trunc_q, trunc_d;
`endif

    // Wrapped scan starting at the rr pointer. The loop runs from the largest
    // offset down, so the smallest offset with a set req bit is kept last.
    logic              win_found;
    logic [IDXW-1:0]   win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IDXW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    logic [WIDTH-1:0] sel_wdata;
    logic             last_write;
    logic             do_release;

    assign sel_wdata  = wdata[gidx_q*WIDTH +: WIDTH];
    assign last_write = (burst_q == 4'(MAX_BURST - 1));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        gidx_d     = gidx_q;
        burst_d    = burst_q;
        do_release = 1'b0;
`ifdef REG_WRITE_ARBITER_STATS_EN
        wr_count_d = wr_count_q;
        trunc_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    gidx_d  = win_idx;
                    burst_d = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!req[gidx_q]) begin
                    do_release = 1'b1;
                end else begin
                    q_d       = sel_wdata;
                    owner_d   = gidx_q;
                    q_valid_d = 1'b1;
                    burst_d   = burst_q + 4'd1;
`ifdef REG_WRITE_ARBITER_STATS_EN
                    if (wr_count_q != 16'hFFFF) begin
                        wr_count_d = wr_count_q + 16'd1;
                    end
                    trunc_d = lock[gidx_q] && last_write;
`endif
                    if (!lock[gidx_q] || last_write) begin
                        do_release = 1'b1;
                    end
                end
                // A release always lands in IDLE with gnt cleared, which
                // creates the mandatory one-cycle bubble between owners.
                if (do_release) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                    rr_d    = (int'(gidx_q) == NREQ - 1) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            owner_q    <= '0;
            rr_q       <= '0;
            gidx_q     <= '0;
            burst_q    <= '0;
`ifdef REG_WRITE_ARBITER_STATS_EN
            wr_count_q <= '0;
            trunc_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            q_q        <= q_d;
            q_valid_q  <= q_valid_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            gidx_q     <= gidx_d;
            burst_q    <= burst_d;
`ifdef REG_WRITE_ARBITER_STATS_EN
            wr_count_q <= wr_count_d;
            trunc_q    <= trunc_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign owner   = owner_q;
`ifdef REG_WRITE_ARBITER_STATS_EN
    assign wr_count    = wr_count_q;
    assign burst_trunc = trunc_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Directed testbench for reg_write_arbiter (NREQ=4, WIDTH=8, MAX_BURST=4).
// Inputs are driven one time unit after a rising edge. Outputs are sampled
// at that same point, so each sample shows the state left by the most
// recent edge.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [1:0]            owner;
`ifdef REG_WRITE_ARBITER_STATS_EN
    logic [15:0]           wr_count;
    logic                  burst_trunc;
`endif

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(.NREQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .owner   (owner)
`ifdef REG_WRITE_ARBITER_STATS_EN
        ,
        .wr_count    (wr_count),
        .burst_trunc (burst_trunc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        #2;
        checks++;
        if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_state gnt=%b q=%h q_valid=%b owner=%0d required gnt=0000 q=00 q_valid=0 owner=0",
                     gnt, q, q_valid, owner);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL idle_no_req cycle %0d gnt=%b required 0000", c, gnt);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        req   = 4'b0001;
        lock  = 4'b0000;
        wdata = '0;
        wdata[7:0] = 8'hA5;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant gnt=%b required 0001", gnt);
        end
        tick();
        checks++;
        if (q !== 8'hA5 || q_valid !== 1'b1 || owner !== 2'd0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_write q=%h q_valid=%b owner=%0d gnt=%b required q=a5 q_valid=1 owner=0 gnt=0000",
                     q, q_valid, owner, gnt);
        end
        req = 4'b0000;
        tick();
        $display("single write: q=%h owner=%0d", q, owner);
    endtask

    // A requester holding a locked grant is cut off by reset, which acts
    // immediately rather than at the next clock edge. The rr pointer returns to 0.
    task automatic test_async_reset();
        req   = 4'b0010;
        lock  = 4'b0010;
        wdata = '0;
        wdata[15:8] = 8'h55;
        tick();
        tick();
        checks++;
        if (q !== 8'h55 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL async_pre q=%h gnt=%b required q=55 gnt=0010", q, gnt);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || q !== 8'h00 || q_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset gnt=%b q=%h q_valid=%b required gnt=0000 q=00 q_valid=0",
                     gnt, q, q_valid);
        end
        req  = 4'b0000;
        lock = 4'b0000;
        #1;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d gnt=%b required 0000", c, gnt);
            end
        end
        $display("async reset: gnt=%b q=%h", gnt, q);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [9];
        exp_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        req  = 4'b1111;
        lock = 4'b0000;
        for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = 8'(8'h20 + i);
        for (int s = 0; s < 9; s++) begin
            tick();
            checks++;
            if (gnt !== exp_gnt[s]) begin
                errors++;
                $display("FAIL rr_gnt step %0d gnt=%b required %b", s, gnt, exp_gnt[s]);
            end
            // Each odd step follows the write made by requester s/2.
            if (s % 2 == 1) begin
                checks++;
                if (q !== 8'(8'h20 + s / 2) || owner !== 2'(s / 2)) begin
                    errors++;
                    $display("FAIL rr_write step %0d q=%h owner=%0d required q=%h owner=%0d",
                             s, q, owner, 8'(8'h20 + s / 2), s / 2);
                end
            end
            $display("round robin step %0d: gnt=%b q=%h", s, gnt, q);
        end
        // Requester 0 drops its request while granted, so it is released
        // without writing.
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || q !== 8'h23 || owner !== 2'd3) begin
            errors++;
            $display("FAIL rr_drop gnt=%b q=%h owner=%0d required gnt=0000 q=23 owner=3",
                     gnt, q, owner);
        end
    endtask

    task automatic test_locked_burst();
        req   = 4'b0010;
        lock  = 4'b0010;
        wdata = '0;
        wdata[15:8] = 8'h10;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL burst_grant gnt=%b required 0010", gnt);
        end
        req = 4'b0110;
        for (int w = 0; w < 4; w++) begin
            wdata[15:8] = 8'(8'h10 + w);
            tick();
            checks++;
            if (q !== 8'(8'h10 + w) || gnt !== ((w == 3) ? 4'b0000 : 4'b0010)) begin
                errors++;
                $display("FAIL burst_write %0d q=%h gnt=%b required q=%h gnt=%b", w, q, gnt,
                         8'(8'h10 + w), (w == 3) ? 4'b0000 : 4'b0010);
            end
`ifdef REG_WRITE_ARBITER_STATS_EN
            checks++;
            if (burst_trunc !== (w == 3)) begin
                errors++;
                $display("FAIL burst_trunc write %0d got %b required %b", w, burst_trunc, w == 3);
            end
`endif
            $display("burst write %0d: q=%h gnt=%b", w, q, gnt);
        end
        wdata[15:8] = 8'h14;
        tick();
        checks++;
        if (gnt !== 4'b0100 || q !== 8'h13) begin
            errors++;
            $display("FAIL burst_handover gnt=%b q=%h required gnt=0100 q=13", gnt, q);
        end
`ifdef REG_WRITE_ARBITER_STATS_EN
        checks++;
        if (burst_trunc !== 1'b0) begin
            errors++;
            $display("FAIL burst_trunc_pulse got %b required 0", burst_trunc);
        end
`endif
        req  = 4'b0000;
        lock = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || q !== 8'h13) begin
            errors++;
            $display("FAIL burst_release2 gnt=%b q=%h required gnt=0000 q=13", gnt, q);
        end
    endtask

    task automatic test_dropped_request();
        req   = 4'b1000;
        lock  = 4'b1000;
        wdata = '0;
        wdata[31:24] = 8'h30;
        tick();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL drop_grant gnt=%b required 1000", gnt);
        end
        tick();
        wdata[31:24] = 8'h31;
        tick();
        checks++;
        if (q !== 8'h31 || gnt !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL drop_two_writes q=%h gnt=%b owner=%0d required q=31 gnt=1000 owner=3",
                     q, gnt, owner);
        end
        req = 4'b0000;
        wdata[31:24] = 8'h32;
        tick();
        checks++;
        if (q !== 8'h31 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL drop_release q=%h gnt=%b required q=31 gnt=0000", q, gnt);
        end
        // The rr pointer must have wrapped to 0, so requester 0 wins when all four request.
        req  = 4'b1111;
        lock = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL drop_rr_wrap gnt=%b required 0001", gnt);
        end
        req = 4'b0000;
        tick();
        tick();
        $display("dropped request: q=%h gnt=%b", q, gnt);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_async_reset();
        test_round_robin();
        test_locked_burst();
        test_dropped_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
